// File: rtl/mips_fetch_pkg.sv
// Shared widths, reset default and the buffered-instruction record for the fetch stage.
package mips_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order buffer of fetched {instr, pc} entries with flush; the head is read combinationally.
module fetch_fifo
    import mips_fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  fetch_entry_t     push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i & ~flush_i;
    assign do_pop  = pop_i & ~flush_i & (count_q != '0);

    // NOTE: the storage array is deliberately not reset; count_q alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch stage: PC, credit-limited imem requests, in-order response buffering,
// decode-stall absorption and redirect flushing of in-flight fetches.
module mips_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               id_stall,
    output logic               fetch_valid,
    output logic [INSTR_W-1:0] fetch_instr,
    output logic [ADDR_W-1:0]  fetch_pc
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [CNT_W-1:0]  count;
    logic [SUM_W-1:0]  credit_used;
    logic [ADDR_W-1:0] redirect_base;
    fetch_entry_t      head;
    logic              pop, req_fire, resp_fire, keep, flushing;

    assign redirect_base = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign fetch_valid   = (count != '0);
    assign pop           = fetch_valid & ~id_stall & ~redirect_valid;
    assign credit_used   = SUM_W'(inflight_q) + SUM_W'(count) - SUM_W'(pop);

    // Gated by rst_n so the request is low while reset is held and rises in the first cycle after release.
    assign imem_req_valid = rst_n & ~redirect_valid & (credit_used < SUM_W'(FIFO_DEPTH));
    assign imem_req_addr  = pc_q;

    assign req_fire  = imem_req_valid & imem_req_ready;
    assign resp_fire = imem_resp_valid & (inflight_q != '0);
    assign flushing  = (drop_q != '0);
    assign keep      = resp_fire & ~flushing & ~redirect_valid;

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        pc_d       = pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        if (redirect_valid) begin
            pc_d       = redirect_base;
            resp_pc_d  = redirect_base;
            inflight_d = inflight_q - CNT_W'(resp_fire);
            drop_d     = inflight_q - CNT_W'(resp_fire);
        end else begin
            if (req_fire) pc_d = pc_q + ADDR_W'(4);
            inflight_d = inflight_q + CNT_W'(req_fire) - CNT_W'(resp_fire);
            if (keep) begin
                resp_pc_d = resp_pc_q + ADDR_W'(4);
            end else if (resp_fire) begin
                drop_d = drop_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (keep),
        .push_data_i ({imem_resp_data, resp_pc_q}),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .head_o      (head),
        .count_o     (count)
    );

    assign fetch_instr = fetch_valid ? head.instr : '0;
    assign fetch_pc    = fetch_valid ? head.pc    : '0;

    resp_without_request_a : assert property (@(posedge clk) disable iff (!rst_n)
        imem_resp_valid |-> (inflight_q != '0));

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Bench for mips_fetch_unit: in-order memory model plus an epoch-tagged expected-stream scoreboard.
module tb_mips_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] MAGIC    = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic        fetch_valid;
    logic [31:0] fetch_instr, fetch_pc;

    mips_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .id_stall        (id_stall),
        .fetch_valid     (fetch_valid),
        .fetch_instr     (fetch_instr),
        .fetch_pc        (fetch_pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ MAGIC;
    endfunction

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc = RESET_PC;
    int          epoch = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          mem_lat = 1;

    // Memory: returns pending requests in order, one per cycle, no earlier than their due cycle.
    always begin
        @(posedge clk);
        cyc++;
        #1;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(pend[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
    end

    // Scoreboard: kept responses form the expected instruction stream; a redirect starts a new epoch.
    always @(negedge clk) begin
        logic        pop_m, exp_req, accept, kept;
        logic [31:0] resp_addr;
        int          used, d;
        if (!rst_n) begin
            check("rst_req_valid", imem_req_valid, 32'd0);
            check("rst_req_addr", imem_req_addr, RESET_PC);
            check("rst_fetch_valid", fetch_valid, 32'd0);
            check("rst_fetch_instr", fetch_instr, 32'd0);
            check("rst_fetch_pc", fetch_pc, 32'd0);
            pend.delete();
            exp_q.delete();
            exp_pc   = RESET_PC;
            last_due = 0;
        end else begin
            pop_m   = (exp_q.size() != 0) && !id_stall && !redirect_valid;
            used    = pend.size() + exp_q.size() - int'(pop_m);
            exp_req = !redirect_valid && (used < DEPTH);
            check("fetch_valid", fetch_valid, 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check("fetch_pc", fetch_pc, exp_q[0]);
                check("fetch_instr", fetch_instr, mem_word(exp_q[0]));
            end else begin
                check("idle_fetch_pc", fetch_pc, 32'd0);
                check("idle_fetch_instr", fetch_instr, 32'd0);
            end
            check("req_valid", imem_req_valid, 32'(exp_req));
            if (exp_req) check("req_addr", imem_req_addr, exp_pc);
            accept    = exp_req && imem_req_ready;
            kept      = 1'b0;
            resp_addr = '0;
            if (imem_resp_valid && pend.size() != 0) begin
                kept      = (pend[0].epoch == epoch) && !redirect_valid;
                resp_addr = pend[0].addr;
                void'(pend.pop_front());
            end
            if (redirect_valid) begin
                exp_q.delete();
                epoch++;
                exp_pc = {redirect_pc[31:2], 2'b00};
            end else begin
                if (pop_m) void'(exp_q.pop_front());
                if (kept) exp_q.push_back(resp_addr);
                if (accept) begin
                    d = cyc + mem_lat;
                    if (d <= last_due) d = last_due + 1;
                    pend.push_back('{addr: exp_pc, due: d, epoch: epoch});
                    last_due = d;
                    exp_pc   = exp_pc + 32'd4;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_stall       = 1'b0;
        repeat (3) step();
        at_neg();
        check("lit_reset_req_valid", imem_req_valid, 32'd0);

        // Cold start, L=1: cycle 1 is the first cycle with rst_n high.
        step(); rst_n = 1'b1;
        at_neg(); check("lit_c1_req_valid", imem_req_valid, 32'd1);
                  check("lit_c1_req_addr", imem_req_addr, 32'h0);
        step(); at_neg(); check("lit_c2_req_addr", imem_req_addr, 32'h4);
                          check("lit_c2_fetch_valid", fetch_valid, 32'd0);
        step(); at_neg(); check("lit_c3_fetch_valid", fetch_valid, 32'd1);
                          check("lit_c3_fetch_pc", fetch_pc, 32'h0);
                          check("lit_c3_fetch_instr", fetch_instr, 32'hDEAD_BEEF);
        step(); at_neg(); check("lit_c4_fetch_pc", fetch_pc, 32'h4);
                          check("lit_c4_fetch_instr", fetch_instr, 32'hDEAD_BEEB);
        repeat (4) step();

        // Decode stall for cycles 9..13, then drain.
        step(); id_stall = 1'b1;
        at_neg(); check("lit_stall_head0", fetch_pc, 32'h18);
        repeat (4) step();
        at_neg(); check("lit_stall_req_valid", imem_req_valid, 32'd0);
                  check("lit_stall_head", fetch_pc, 32'h18);
        step(); id_stall = 1'b0;
        for (int k = 0; k < 5; k++) begin
            at_neg();
            check("lit_drain_valid", fetch_valid, 32'd1);
            check("lit_drain_pc", fetch_pc, 32'h18 + 32'(4 * k));
            step();
        end

        // L=3 stream, then redirect while a response is arriving.
        mem_lat = 3;
        repeat (7) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        at_neg(); check("lit_redir_req_valid", imem_req_valid, 32'd0);
        step(); redirect_valid = 1'b0;
        at_neg(); check("lit_r1_fetch_valid", fetch_valid, 32'd0);
                  check("lit_r1_req_valid", imem_req_valid, 32'd1);
                  check("lit_r1_req_addr", imem_req_addr, 32'h100);
        for (int k = 2; k <= 4; k++) begin
            step(); at_neg(); check("lit_flush_fetch_valid", fetch_valid, 32'd0);
        end
        step(); at_neg(); check("lit_r5_fetch_pc", fetch_pc, 32'h100);
                          check("lit_r5_fetch_instr", fetch_instr, 32'hDEAD_BFEF);
        step(); at_neg(); check("lit_r6_fetch_pc", fetch_pc, 32'h104);
                          check("lit_r6_fetch_instr", fetch_instr, 32'hDEAD_BFEB);

        // Buffer a couple of entries, then reset mid-operation.
        step(); id_stall = 1'b1;
        step();
        step();
        check("lit_prerst_fetch_valid", fetch_valid, 32'd1);
        rst_n = 1'b0;
        #1;
        check("lit_async_rst_fetch_valid", fetch_valid, 32'd0);
        check("lit_async_rst_fetch_pc", fetch_pc, 32'd0);
        id_stall = 1'b0;
        mem_lat  = 2;
        repeat (2) step();

        // Memory not ready for 4 cycles after release; acceptance on cycle 5.
        imem_req_ready = 1'b0;
        step(); rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            at_neg();
            check("lit_hold_req_valid", imem_req_valid, 32'd1);
            check("lit_hold_req_addr", imem_req_addr, RESET_PC);
            step();
        end
        imem_req_ready = 1'b1;
        at_neg(); check("lit_c5_req_addr", imem_req_addr, 32'h0);
        step(); at_neg(); check("lit_c6_req_addr", imem_req_addr, 32'h4);
        repeat (12) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
